unpack_1d_to_2d_stream: RTL

Inverse of the team's 2D-to-1D packing path: accepts one flat packed word per handshake, with column 0 in the least-significant field, and replays its columns as a one-element-per-cycle valid/ready stream. It also exposes a registered 2D copy of the captured word. The block sits between wide packed buses (memory read ports, inter-block links) and element-serial consumers such as per-column accumulators.

---
 rtl/unpack_1d_to_2d_stream_pkg.sv | 37 +++
 rtl/unpack_1d_to_2d_stream_convert.sv | 19 +
 rtl/unpack_1d_to_2d_stream.sv | 107 ++++++++++
 3 files changed

// File: rtl/unpack_1d_to_2d_stream_pkg.sv
// Shared definitions for the 1D/2D packing and unpacking paths.
package unpack_1d_to_2d_stream_pkg;

    localparam int unsigned MAX_FIELD_W = 64;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    // Resolves the -1 "same as BIT_WIDTH" encoding of a field width.
    function automatic int unsigned final_width(input int bit_width, input int out_or_in_bit_width);
        return (out_or_in_bit_width < 0) ? unsigned'(bit_width) : unsigned'(out_or_in_bit_width);
    endfunction

    // Truncates or extends an in_w-bit field to out_w bits.
    function automatic logic [MAX_FIELD_W-1:0] convert_field(
        input logic [MAX_FIELD_W-1:0] field,
        input int unsigned            in_w,
        input int unsigned            out_w,
        input logic                   sign_ext
    );
        logic [MAX_FIELD_W-1:0] in_mask;
        logic [MAX_FIELD_W-1:0] out_mask;
        logic [MAX_FIELD_W-1:0] res;
        in_mask  = (in_w >= MAX_FIELD_W) ? '1
                 : ((MAX_FIELD_W'(1) << in_w) - MAX_FIELD_W'(1));
        out_mask = (out_w >= MAX_FIELD_W) ? '1
                 : ((MAX_FIELD_W'(1) << out_w) - MAX_FIELD_W'(1));
        res = field & in_mask;
        if (sign_ext && (|(field & in_mask & ~(in_mask >> 1)))) begin
            res = res | ~in_mask;
        end
        return res & out_mask;
    endfunction

endpackage

// File: rtl/unpack_1d_to_2d_stream_convert.sv
// Combinational split of a flat word into width-converted elements; field i -> element i.
module convert_1d_to_2d_array_size
    import unpack_1d_to_2d_stream_pkg::*;
#(
    parameter int          BIT_WIDTH = 4,
    parameter int unsigned IN_W      = 4,
    parameter int          COLS      = 8,
    parameter int          SIGNED    = 0
) (
    input  logic [COLS*IN_W-1:0]            in_data_i,
    output logic [COLS-1:0][BIT_WIDTH-1:0]  array_o
);

    for (genvar i = 0; i < COLS; i++) begin : g_field
        assign array_o[i] = BIT_WIDTH'(convert_field(MAX_FIELD_W'(in_data_i[i*IN_W +: IN_W]),
                                                     IN_W, unsigned'(BIT_WIDTH), SIGNED != 0));
    end

endmodule

// File: rtl/unpack_1d_to_2d_stream.sv
// Captures a packed word and replays its columns as a one-element-per-cycle stream.
module unpack_1d_to_2d_stream
    import unpack_1d_to_2d_stream_pkg::*;
#(
    parameter int BIT_WIDTH    = 4,
    parameter int IN_BIT_WIDTH = -1,
    parameter int COLS         = 8,
    parameter int SIGNED       = 0
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [COLS*final_width(BIT_WIDTH, IN_BIT_WIDTH)-1:0] in_data,
    input  logic [$clog2(COLS+1)-1:0]                           in_num_cols,
    output logic                                                out_valid,
    input  logic                                                out_ready,
    output logic [BIT_WIDTH-1:0]                                out_data,
    output logic [$clog2(COLS)-1:0]                             out_col,
    output logic                                                out_last,
    output logic [COLS-1:0][BIT_WIDTH-1:0]                      out_array
);

    localparam int unsigned IN_W = final_width(BIT_WIDTH, IN_BIT_WIDTH);
    localparam int unsigned CW   = $clog2(COLS);
    localparam int unsigned NW   = $clog2(COLS + 1);

    typedef logic [COLS-1:0][BIT_WIDTH-1:0] arr_t;

    state_e          state_q, state_d;
    arr_t            buf_q, buf_d, conv;
    logic [CW-1:0]   col_q, col_d;
    logic [CW-1:0]   last_q, last_d;
    logic [CW-1:0]   last_eff;
    logic            capture;

    convert_1d_to_2d_array_size #(
        .BIT_WIDTH (BIT_WIDTH),
        .IN_W      (IN_W),
        .COLS      (COLS),
        .SIGNED    (SIGNED)
    ) u_convert (
        .in_data_i (in_data),
        .array_o   (conv)
    );

    // Index of the final column; 0 or out-of-range requests mean the full word.
    always_comb begin
        if (in_num_cols == '0 || in_num_cols > NW'(COLS)) begin
            last_eff = CW'(COLS - 1);
        end else begin
            last_eff = CW'(in_num_cols - NW'(1));
        end
    end

    assign out_valid = (state_q == STREAM);
    assign out_last  = (state_q == STREAM) && (col_q == last_q);
    assign out_data  = buf_q[col_q];
    assign out_col   = col_q;
    assign out_array = buf_q;
    assign in_ready  = (state_q == IDLE) || (out_last && out_ready);
    assign capture   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        last_d  = last_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (out_ready) begin
                    if (!out_last) begin
                        col_d = CW'(col_q + CW'(1));
                    end else if (!in_valid) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (capture) begin
            buf_d  = conv;
            col_d  = '0;
            last_d = last_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            col_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            col_q   <= col_d;
            last_q  <= last_d;
        end
    end

endmodule
